// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder with start/busy/done handshake.
//
// A start pulse in IDLE captures both operands. The adder then processes one
// bit per clock, LSB first, through a pair of Half_adder cells and a carry
// flop. After WIDTH bits the result and carry-out are loaded into the output
// registers, and done pulses for one cycle.
//
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - request a new addition (only looked at in IDLE)
//   a, b  - WIDTH-bit operands, captured on the accepting edge
//   busy  - high while bits are being shifted through the adder
//   done  - one-cycle pulse when sum/cout hold a fresh result
//   sum   - registered (a+b) mod 2^WIDTH, held until the next completion
//   cout  - registered carry-out of the MSB, held with sum

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT            r_state;
  stateT            w_nextState;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_shift;
  logic             r_carry;
  logic [CW-1:0]    r_bitCount;

  logic w_accept;
  logic w_lastBit;
  logic w_ha1Sum;
  logic w_ha1Carry;
  logic w_sumBit;
  logic w_ha2Carry;
  logic w_carryD;

  // Full-adder bit slice built from two half adders: operand bits first, then
  // the running carry. Both half-adder carries can never be high together,
  // so an OR is enough to form the next carry.
  Half_adder u_ha1 (
    .a     (r_opA[0]),
    .b     (r_opB[0]),
    .sum   (w_ha1Sum),
    .carry (w_ha1Carry)
  );

  Half_adder u_ha2 (
    .a     (w_ha1Sum),
    .b     (r_carry),
    .sum   (w_sumBit),
    .carry (w_ha2Carry)
  );

  assign w_carryD = w_ha1Carry | w_ha2Carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_lastBit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = SHIFT;
          w_accept    = 1'b1;
        end
      end
      SHIFT: begin
        if (r_bitCount == LAST_BIT) begin
          w_nextState = DONE;
          w_lastBit   = 1'b1;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. busy/done are computed from the next
  // state so they line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_shift    <= '0;
      r_carry    <= 1'b0;
      r_bitCount <= '0;
    end else begin
      busy <= (w_nextState == SHIFT);
      done <= (w_nextState == DONE);
      if (w_accept) begin
        r_opA      <= a;
        r_opB      <= b;
        r_shift    <= '0;
        r_carry    <= 1'b0;
        r_bitCount <= '0;
      end else if (r_state == SHIFT) begin
        r_opA      <= {1'b0, r_opA[WIDTH-1:1]};
        r_opB      <= {1'b0, r_opB[WIDTH-1:1]};
        r_shift    <= {w_sumBit, r_shift[WIDTH-1:1]};
        r_carry    <= w_carryD;
        r_bitCount <= r_bitCount + 1'b1;
        // The final bit is still in flight, so it is merged in here directly
        // instead of waiting for it to land in r_shift.
        if (w_lastBit) begin
          sum  <= {w_sumBit, r_shift[WIDTH-1:1]};
          cout <= w_carryD;
        end
      end
    end
  end

endmodule

// Half_adder -- one-bit half adder cell.
//   a, b  - input bits
//   sum   - a XOR b
//   carry - a AND b
module Half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl -- self-checking bench for serial_add_ctrl (WIDTH=8).
// Expected results come from plain integer addition of the operands. Timing
// expectations come from the handshake rules: done is visible WIDTH+1 edges
// after the accepting edge (that edge included), and busy is high for WIDTH
// cycles.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the sum and carry-out of an 8-bit addition.
  function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Launch one operation from IDLE and wait (bounded) for done. Optionally
  // scramble start/a/b while busy. Returns the edge count from the accepting
  // edge (inclusive) to done, the number of cycles busy was seen high, and
  // the done value one edge after the pulse.
  task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input bit scramble,
                       output int lat, output int busyCnt, output bit seen,
                       output logic doneAfter);
    start = 1'b1; a = x; b = y;
    tick();
    start = 1'b0;
    lat = 1; busyCnt = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); start = 1'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    tick();
    doneAfter = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("[TB] FAIL reset_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got=%b want=0", cout); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_start_busy got=%b want=0", busy); end
  endtask

  task automatic test_zero_timing();
    int lat, bc; bit seen; logic da;
    runOp(8'h00, 8'h00, 1'b0, lat, bc, seen, da);
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL zero_done_timeout got=%b want=1", seen); end
    checks++; if (lat != W + 1) begin failures++; $display("[TB] FAIL zero_latency got=%0d want=%0d", lat, W + 1); end
    checks++; if (bc != W) begin failures++; $display("[TB] FAIL zero_busy_cycles got=%0d want=%0d", bc, W); end
    checks++; if (sum !== 8'h00) begin failures++; $display("[TB] FAIL zero_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL zero_cout got=%b want=0", cout); end
    checks++; if (da !== 1'b0) begin failures++; $display("[TB] FAIL zero_done_width got=%b want=0", da); end
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [3] = '{8'h5A, 8'hC8, 8'hFF};
    logic [W-1:0] ys [3] = '{8'h33, 8'h64, 8'h01};
    logic [W-1:0] es [3] = '{8'h8D, 8'h2C, 8'h00};
    logic         ec [3] = '{1'b0, 1'b1, 1'b1};
    int lat, bc; bit seen; logic da;
    for (int k = 0; k < 3; k++) begin
      runOp(xs[k], ys[k], 1'b0, lat, bc, seen, da);
      checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL directed%0d_timeout got=%b want=1", k, seen); end
      checks++; if (sum !== es[k]) begin failures++; $display("[TB] FAIL directed%0d_sum got=%h want=%h", k, sum, es[k]); end
      checks++; if (cout !== ec[k]) begin failures++; $display("[TB] FAIL directed%0d_cout got=%b want=%b", k, cout, ec[k]); end
    end
    // The last case (0xFF+0x01) must hold its result while idle.
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
    end
    checks++; if (sum !== 8'h00) begin failures++; $display("[TB] FAIL hold_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("[TB] FAIL hold_cout got=%b want=1", cout); end
  endtask

  task automatic test_ignore_while_busy();
    bit seen; int extra;
    start = 1'b1; a = 8'h0F; b = 8'h01;
    tick();
    start = 1'b0;
    tick(); tick();
    // Request a new operation from E3 on; it must be ignored.
    start = 1'b1; a = 8'hAA; b = 8'h55;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL ignore_timeout got=%b want=1", seen); end
    checks++; if (sum !== 8'h10) begin failures++; $display("[TB] FAIL ignore_sum got=%h want=10", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL ignore_cout got=%b want=0", cout); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy || done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("[TB] FAIL ignore_second_op got=%0d want=0", extra); end
  endtask

  task automatic test_mid_reset();
    int pulses, lat, bc; bit seen; logic da;
    start = 1'b1; a = 8'h77; b = 8'h99;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
    checks++; if (sum !== 8'h00) begin failures++; $display("[TB] FAIL midrst_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL midrst_cout got=%b want=0", cout); end
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL midrst_activity got=%0d want=0", pulses); end
    runOp(8'h01, 8'h02, 1'b0, lat, bc, seen, da);
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL midrst_next_timeout got=%b want=1", seen); end
    checks++; if (sum !== 8'h03) begin failures++; $display("[TB] FAIL midrst_next_sum got=%h want=03", sum); end
    checks++; if (lat != W + 1) begin failures++; $display("[TB] FAIL midrst_next_latency got=%0d want=%0d", lat, W + 1); end
  endtask

  task automatic test_back_to_back();
    int prev, pulses;
    prev = -1; pulses = 0;
    start = 1'b1; a = 8'h80; b = 8'h80;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (done) begin
        pulses++;
        checks++; if (sum !== 8'h00) begin failures++; $display("[TB] FAIL b2b_sum got=%h want=00", sum); end
        checks++; if (cout !== 1'b1) begin failures++; $display("[TB] FAIL b2b_cout got=%b want=1", cout); end
        if (prev >= 0) begin
          checks++; if (i - prev != W + 2) begin failures++; $display("[TB] FAIL b2b_period got=%0d want=%0d", i - prev, W + 2); end
        end
        prev = i;
      end
    end
    start = 1'b0;
    checks++; if (pulses != 3) begin failures++; $display("[TB] FAIL b2b_pulse_count got=%0d want=3", pulses); end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic [W:0]   exp;
    int lat, bc; bit seen; logic da;
    for (int n = 0; n < 25; n++) begin
      x = W'($urandom); y = W'($urandom);
      exp = refAdd(x, y);
      runOp(x, y, 1'b1, lat, bc, seen, da);
      checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL rand%0d_timeout got=%b want=1", n, seen); end
      checks++; if ({cout, sum} !== exp) begin failures++; $display("[TB] FAIL rand%0d_result a=%h b=%h got=%b_%h want=%b_%h", n, x, y, cout, sum, exp[W], exp[W-1:0]); end
      checks++; if (lat != W + 1) begin failures++; $display("[TB] FAIL rand%0d_latency got=%0d want=%0d", n, lat, W + 1); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_zero_timing();
    test_directed();
    test_ignore_while_busy();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
